// File: rtl/spi_arb_pkg.sv
// Shared types and default constants for the SPI chip-select sequencer/arbiter.
// Imported by spi_arbiter and rr_arbiter.
package spi_arb_pkg;

   localparam int N_REQ_DEF       = 4;
   localparam int DATA_W_DEF      = 8;
   localparam int SETUP_CYC_DEF   = 4;
   localparam int GAP_CYC_DEF     = 8;
   localparam int TIMEOUT_CYC_DEF = 65535;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      GAP   = 3'd4
   } state_t;

   // Sizes the shared phase counter so it can hold the longest phase length.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter
   import spi_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     valid
);

   localparam int IDX_W = $clog2(N_REQ);

   // NOTE: every output gets a default before the loop so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      // Walk from the farthest candidate to the nearest so the nearest wins.
      for (int off = N_REQ - 1; off >= 0; off--) begin
         logic [IDX_W-1:0] pos;
         pos = IDX_W'((int'(ptr) + off) % N_REQ);
         if (req[pos]) begin
            gnt      = '0;
            gnt[pos] = 1'b1;
            idx      = pos;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master byte engine among N_REQ requesters, owning chip-select
// setup, inter-transfer gap and a per-transfer timeout.
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SETUP_CYC   = SETUP_CYC_DEF,
   parameter int GAP_CYC     = GAP_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        ack,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_err,
   output logic                    busy,
   output logic                    m_start,
   output logic [DATA_W-1:0]       m_data_in,
   input  logic                    m_done,
   input  logic [DATA_W-1:0]       m_data_out,
   output logic [N_REQ-1:0]        cs_n
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(max3(SETUP_CYC, GAP_CYC, TIMEOUT_CYC) + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]   gidx, gidx_nxt;
   logic [IDX_W-1:0]   ptr, ptr_nxt;
   logic [N_REQ-1:0]   cs_n_nxt;
   logic [N_REQ-1:0]   ack_nxt;
   logic [DATA_W-1:0]  rsp_data_nxt;
   logic               rsp_err_nxt;
   logic [DATA_W-1:0]  m_data_in_nxt;

   logic [N_REQ-1:0]   arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;
   logic               finish;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req   (req),
      .ptr   (ptr),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign busy    = (state != IDLE);
   assign m_start = (state == START);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      gidx_nxt      = gidx;
      ptr_nxt       = ptr;
      cs_n_nxt      = cs_n;
      ack_nxt       = '0;
      rsp_data_nxt  = rsp_data;
      rsp_err_nxt   = rsp_err;
      m_data_in_nxt = m_data_in;
      finish        = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (arb_valid) begin
               gidx_nxt      = arb_idx;
               m_data_in_nxt = req_data[int'(arb_idx)*DATA_W +: DATA_W];
               cs_n_nxt      = ~arb_gnt;
               state_nxt     = SETUP;
            end
         end

         SETUP: begin
            if (cnt >= SETUP_LAST) state_nxt = START;
         end

         START: begin
            cnt_nxt   = '0;
            state_nxt = WAIT;
         end

         WAIT: begin
            // A completion in the same cycle as the timeout still counts as good.
            if (m_done) begin
               rsp_data_nxt = m_data_out;
               rsp_err_nxt  = 1'b0;
               finish       = 1'b1;
            end else if (cnt >= TIMEOUT_LAST) begin
               rsp_data_nxt = '0;
               rsp_err_nxt  = 1'b1;
               finish       = 1'b1;
            end
            if (finish) begin
               ack_nxt       = '0;
               ack_nxt[gidx] = 1'b1;
               cs_n_nxt      = '1;
               ptr_nxt       = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
               cnt_nxt       = '0;
               state_nxt     = GAP;
            end
         end

         GAP: begin
            if (cnt >= GAP_LAST) state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         gidx      <= '0;
         ptr       <= '0;
         cs_n      <= '1;
         ack       <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         m_data_in <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         gidx      <= gidx_nxt;
         ptr       <= ptr_nxt;
         cs_n      <= cs_n_nxt;
         ack       <= ack_nxt;
         rsp_data  <= rsp_data_nxt;
         rsp_err   <= rsp_err_nxt;
         m_data_in <= m_data_in_nxt;
      end
   end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: scoreboard of expected grants/responses,
// behavioural SPI master that answers tx ^ 8'h99 after a programmable delay.
module tb_spi_arbiter;
   import spi_arb_pkg::*;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int SETUP = 4;
   localparam int GAP_C = 8;
   localparam int TMO   = 50;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   ack;
   logic [W-1:0]   rsp_data;
   logic           rsp_err;
   logic           busy;
   logic           m_start;
   logic [W-1:0]   m_data_in;
   logic           m_done = 1'b0;
   logic [W-1:0]   m_data_out = '0;
   logic [N-1:0]   cs_n;

   always #5 clk = ~clk;

   spi_arbiter #(
      .N_REQ       (N),
      .DATA_W      (W),
      .SETUP_CYC   (SETUP),
      .GAP_CYC     (GAP_C),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .ack        (ack),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .m_start    (m_start),
      .m_data_in  (m_data_in),
      .m_done     (m_done),
      .m_data_out (m_data_out),
      .cs_n       (cs_n)
   );

   typedef struct packed {
      logic [1:0]  idx;
      logic [7:0]  tx;
      logic [7:0]  rx;
      logic        err;
      logic [15:0] lat;
   } exp_t;

   exp_t q[$];

   int n_cmp = 0;
   int n_err = 0;

   int       cyc = 0;
   int       start_cyc = 0;
   int       gap_run = 0;
   bit       prev_idle_cs = 1'b1;
   bit       had_xfer = 1'b0;
   int       mdone_cnt = 0;
   int       delay = 3;
   bit       mute = 1'b0;
   bit       spur = 1'b0;
   logic [7:0] resp = '0;
   int       rearm [N];
   bit       pend  [N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int idx, input logic [7:0] tx, input bit err, input int lat);
      exp_t e;
      e.idx = 2'(idx);
      e.tx  = tx;
      e.rx  = err ? 8'h00 : (tx ^ 8'h99);
      e.err = err;
      e.lat = 16'(lat);
      q.push_back(e);
   endtask

   // One clock: observe outputs at the falling edge, then drive the next inputs.
   task automatic step();
      int   lo;
      exp_t e;
      @(negedge clk);
      cyc++;
      check("cs_onehot", 32'($countones(~cs_n) <= 1), 32'd1);

      if (cs_n == '1) begin
         gap_run      = prev_idle_cs ? gap_run + 1 : 1;
         prev_idle_cs = 1'b1;
      end else begin
         if (prev_idle_cs) begin
            lo = -1;
            for (int i = 0; i < N; i++) if (!cs_n[i]) lo = i;
            check("grant_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) check("grant_idx", 32'(lo), 32'(q[0].idx));
            if (had_xfer) check("cs_gap", 32'(gap_run >= GAP_C + 1), 32'd1);
         end
         prev_idle_cs = 1'b0;
      end

      if (m_start) begin
         start_cyc = cyc;
         if (q.size() != 0) check("tx_byte", 32'(m_data_in), 32'(q[0].tx));
         resp = m_data_in ^ 8'h99;
         // +1 because the countdown is decremented later in this same step.
         if (!mute) mdone_cnt = delay + 1;
      end

      for (int i = 0; i < N; i++) begin
         if (pend[i]) begin
            req[i]  = 1'b1;
            pend[i] = 1'b0;
         end
      end

      if (ack != '0) begin
         check("ack_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check("ack_onehot", 32'(ack), 32'd1 << e.idx);
            check("rsp_data", 32'(rsp_data), 32'(e.rx));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("ack_latency", 32'(cyc - start_cyc), 32'(e.lat));
         end
         had_xfer = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               req[i] = 1'b0;
               if (rearm[i] > 0) begin
                  rearm[i]--;
                  pend[i] = 1'b1;
               end
            end
         end
      end

      m_done = 1'b0;
      if (mdone_cnt > 0) begin
         mdone_cnt--;
         if (mdone_cnt == 0) begin
            m_done     = 1'b1;
            m_data_out = resp;
         end
      end
      if (spur) begin
         m_done     = 1'b1;
         m_data_out = 8'hEE;
         spur       = 1'b0;
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check("drain_left", 32'(q.size()), 32'd0);
      repeat (GAP_C + 3) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < N; i++) begin
         rearm[i] = 0;
         pend[i]  = 1'b0;
      end

      // Reset values
      repeat (3) step();
      check("rst_cs_n", 32'(cs_n), 32'hF);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_m_start", 32'(m_start), 32'd0);
      check("rst_m_data_in", 32'(m_data_in), 32'd0);
      check("rst_rsp", 32'({rsp_err, rsp_data}), 32'd0);
      rst = 1'b0;
      repeat (2) step();

      // All four at once: 0,1,2,3 with a spurious m_done in the first gap
      delay = 3;
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int i = 0; i < N; i++) push(i, req_data[i*W +: W], 1'b0, 4);
      req = 4'b1111;
      n = 0;
      while (q.size() > 3 && n < 200) begin
         step();
         n++;
      end
      spur = 1'b1;
      step();
      step();
      check("spur_gap_ack", 32'(ack), 32'd0);
      check("spur_gap_busy", 32'(busy), 32'd1);
      check("spur_gap_cs", 32'(cs_n), 32'hF);
      drain(400);

      // Fairness: 0 and 3 re-request after each ack
      req_data[0*W +: W] = 8'h5A;
      req_data[3*W +: W] = 8'hC3;
      push(0, 8'h5A, 1'b0, 4);
      push(3, 8'hC3, 1'b0, 4);
      push(0, 8'h5A, 1'b0, 4);
      push(3, 8'hC3, 1'b0, 4);
      rearm[0] = 1;
      rearm[3] = 1;
      req = 4'b1001;
      drain(400);

      // Single request with exact cycle checks
      delay = 20;
      req_data[2*W +: W] = 8'hA5;
      push(2, 8'hA5, 1'b0, 21);
      req[2] = 1'b1;
      step();
      check("single_cs_n", 32'(cs_n), 32'b1011);
      check("single_busy", 32'(busy), 32'd1);
      for (int i = 2; i <= 5; i++) begin
         step();
         check("single_m_start", 32'(m_start), 32'(i == 5));
      end
      check("single_m_data_in", 32'(m_data_in), 32'hA5);
      drain(100);

      // Spurious m_done in IDLE
      spur = 1'b1;
      step();
      step();
      check("spur_idle_ack", 32'(ack), 32'd0);
      check("spur_idle_busy", 32'(busy), 32'd0);
      step();
      check("spur_idle_cs", 32'(cs_n), 32'hF);

      // Timeout, then a normal transfer
      delay = 3;
      mute  = 1'b1;
      req_data[0*W +: W] = 8'h77;
      push(0, 8'h77, 1'b1, TMO + 1);
      req[0] = 1'b1;
      drain(200);
      mute = 1'b0;
      req_data[1*W +: W] = 8'h0F;
      push(1, 8'h0F, 1'b0, 4);
      req[1] = 1'b1;
      drain(100);

      // Reset while in WAIT; afterwards the pointer restarts at 0
      mute = 1'b1;
      req_data[2*W +: W] = 8'h96;
      push(2, 8'h96, 1'b0, 4);
      req[2] = 1'b1;
      n = 0;
      while (!m_start && n < 50) begin
         step();
         n++;
      end
      check("rst_reach_start", 32'(m_start), 32'd1);
      repeat (5) step();
      req_data[1*W +: W] = 8'h3E;
      req[1] = 1'b1;
      rst    = 1'b1;
      step();
      check("midrst_cs_n", 32'(cs_n), 32'hF);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_m_start", 32'(m_start), 32'd0);
      rst       = 1'b0;
      q.delete();
      mdone_cnt = 0;
      had_xfer  = 1'b0;
      mute      = 1'b0;
      push(1, 8'h3E, 1'b0, 4);
      push(2, 8'h96, 1'b0, 4);
      drain(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
